// File: rtl/rr_arbiter_32_if.sv
// rtl/rr_arbiter_32_if.sv - request/grant bundle between requesters and the round-robin arbiter
//
// Signals:
//   req[31:0]      requester i wants the shared resource when bit i is set
//   done           single-cycle release pulse from the current owner
//   grant[31:0]    one-hot grant, zero while idle
//   grant_idx[4:0] binary index of the current (or most recent) owner
//   grant_valid    high while a grant is held
//   timeout        single-cycle pulse when a grant is force-released
// Modports:
//   master - requester side, drives req/done
//   slave  - arbiter side, drives the grant outputs
interface rr_arbiter_32_if;
  logic [31:0] req;
  logic        done;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_32.sv
// rtl/rr_arbiter_32.sv - 32-way round-robin arbiter with optional hold timeout
//
// Parameters:
//   TIMEOUT - cycles a grant may be held without done before forced release
//             (0 disables the forced release, legal range 0..255)
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - rr_arbiter_32_if.slave: req/done in, grant/grant_idx/grant_valid/timeout out
module rr_arbiter_32 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter_32_if.slave   bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Last hold-counter value allowed before the grant is forced off.
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t      state;
  logic [4:0]  ptr;
  logic [7:0]  hold_cnt;

  logic [4:0]  pick_idx;
  logic        pick_found;
  logic [4:0]  cand;
  logic        to_hit;

  // Circular scan starting at ptr; 5-bit addition wraps 31 -> 0 naturally.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int off = 0; off < 32; off++) begin
      cand = ptr + 5'(off);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign to_hit = (TIMEOUT != 0) && (hold_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.grant       <= '0;
      bus.grant_idx   <= '0;
      bus.grant_valid <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          // done is ignored here; grant_idx keeps the last owner.
          if (pick_found) begin
            state           <= BUSY;
            bus.grant       <= 32'd1 << pick_idx;
            bus.grant_idx   <= pick_idx;
            bus.grant_valid <= 1'b1;
            hold_cnt        <= '0;
          end
        end
        BUSY: begin
          // Release always lands in IDLE, so consecutive grants are
          // separated by at least one idle cycle. A done coinciding with
          // the timeout limit counts as a normal release.
          if (bus.done || to_hit) begin
            state           <= IDLE;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            ptr             <= bus.grant_idx + 5'd1;
            bus.timeout     <= !bus.done;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_32.sv
// tb/tb_rr_arbiter_32.sv - scoreboard bench for rr_arbiter_32
module tb_rr_arbiter_32;

  typedef struct {
    int idx;
    int len;
    bit to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  rr_arbiter_32_if bus_if ();

  rr_arbiter_32 #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Monitor: per-cycle one-hot/stability checks, scoreboard compare at grant end.
  bit   prev_valid = 1'b0;
  int   cur_len = 0;
  int   cur_idx = 0;
  exp_t e;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot", bus_if.grant,
          bus_if.grant_valid ? (32'd1 << bus_if.grant_idx) : 32'd0);
      if (bus_if.grant_valid && !prev_valid) begin
        cur_len = 1;
        cur_idx = int'(bus_if.grant_idx);
        chk("timeout_while_busy", 32'(bus_if.timeout), 32'd0);
      end else if (bus_if.grant_valid && prev_valid) begin
        cur_len++;
        chk("idx_held", 32'(bus_if.grant_idx), 32'(cur_idx));
        chk("timeout_while_busy", 32'(bus_if.timeout), 32'd0);
      end else if (!bus_if.grant_valid && prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant_idx", 32'(cur_idx), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("grant_idx", 32'(cur_idx), 32'(e.idx));
          chk("grant_len", 32'(cur_len), 32'(e.len));
          chk("timeout_pulse", 32'(bus_if.timeout), 32'(e.to));
        end
      end else begin
        chk("idle_timeout", 32'(bus_if.timeout), 32'd0);
      end
      prev_valid = bus_if.grant_valid;
    end
  end

  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus_if.grant_valid) break;
    end
    if (!bus_if.grant_valid) chk("wait_grant_expired", 32'(n), 32'd0);
  endtask

  task automatic wait_release();
    int n = 0;
    while (bus_if.grant_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus_if.grant_valid) chk("wait_release_expired", 32'(n), 32'd0);
  endtask

  // Called in grant cycle 1; done is seen on the k-th grant cycle.
  task automatic hold(input int k);
    repeat (k - 1) begin
      @(posedge clk);
      #1;
    end
    bus_if.done = 1'b1;
    @(posedge clk);
    #1;
    bus_if.done = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_grant", bus_if.grant, 32'd0);
    chk("rst_valid", 32'(bus_if.grant_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bus_if.req  = '0;
    bus_if.done = 1'b0;

    #3 rst = 1'b1;
    #1;
    chk("reset_grant", bus_if.grant, 32'd0);
    chk("reset_idx", 32'(bus_if.grant_idx), 32'd0);
    chk("reset_valid", 32'(bus_if.grant_valid), 32'd0);
    chk("reset_timeout", 32'(bus_if.timeout), 32'd0);
    #12 rst = 1'b0;
    mon_en = 1'b1;

    // Single requester, one-cycle arbitration latency.
    sb.push_back('{0, 2, 1'b0});
    @(posedge clk);
    #1;
    bus_if.req = 32'h0000_0001;
    wait_grant(n);
    chk("latency", 32'(n), 32'd1);
    chk("first_grant", bus_if.grant, 32'h0000_0001);
    hold(2);
    bus_if.req = '0;

    // Fairness with all requesting: 0..31 then wrap to 0.
    pulse_reset();
    for (int i = 0; i < 33; i++) sb.push_back('{i % 32, 2, 1'b0});
    bus_if.req = 32'hFFFF_FFFF;
    for (int i = 0; i < 33; i++) begin
      wait_grant(n);
      hold(2);
    end
    bus_if.req = '0;

    // Owner 5 keeps the grant while req moves to bit 8.
    pulse_reset();
    sb.push_back('{5, 4, 1'b0});
    sb.push_back('{8, 2, 1'b0});
    bus_if.req = 32'h0000_0020;
    wait_grant(n);
    bus_if.req = 32'h0000_0100;
    hold(4);
    wait_grant(n);
    hold(2);
    bus_if.req = '0;

    // Forced release after 16 cycles, twice for requester 31.
    pulse_reset();
    sb.push_back('{31, 16, 1'b1});
    sb.push_back('{31, 16, 1'b1});
    bus_if.req = 32'h8000_0000;
    wait_grant(n);
    wait_release();
    wait_grant(n);
    chk("regrant_after_one_idle", 32'(n), 32'd1);
    bus_if.req = '0;
    wait_release();

    // done on the 16th cycle: normal release, no timeout pulse.
    sb.push_back('{0, 16, 1'b0});
    bus_if.req = 32'h0000_0001;
    wait_grant(n);
    hold(16);
    bus_if.req = '0;

    // done while idle changes nothing.
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus_if.done = 1'b1;
    @(posedge clk);
    #1;
    bus_if.done = 1'b0;
    chk("idle_done_idx", 32'(bus_if.grant_idx), 32'd0);
    chk("idle_done_valid", 32'(bus_if.grant_valid), 32'd0);
    sb.push_back('{1, 2, 1'b0});
    bus_if.req = 32'h0000_0003;
    wait_grant(n);
    hold(2);
    bus_if.req = '0;

    // Reset while requester 12 owns the grant.
    pulse_reset();
    sb.push_back('{12, 2, 1'b0});
    bus_if.req = 32'h0000_1000;
    wait_grant(n);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    chk("midgrant_rst_grant", bus_if.grant, 32'd0);
    chk("midgrant_rst_valid", 32'(bus_if.grant_valid), 32'd0);
    bus_if.req = 32'h0000_1001;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("no_grant_before_edge", 32'(bus_if.grant_valid), 32'd0);
    sb.push_back('{0, 2, 1'b0});
    wait_grant(n);
    chk("post_rst_latency", 32'(n), 32'd1);
    hold(2);
    bus_if.req = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_idle", 32'(bus_if.grant_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
